// File: rtl/write_buffer_pkg.sv
// Shared types and defaults for the L1 write-through buffer.
// Entry layout and drain FSM state encoding.
package write_buffer_pkg;

    localparam int WB_ADDR_W = 17;
    localparam int WB_DATA_W = 32;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } wb_state_t;

endpackage

// File: rtl/write_buffer_fwd.sv
// Priority address match over the buffered entries.
// Scans oldest to youngest so the youngest hit wins.
module wb_forward_match #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic [ADDR_W-1:0] ent_addr [DEPTH],
    input  logic [DATA_W-1:0] ent_data [DEPTH],
    input  logic [PTR_W-1:0]  head,
    input  logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    // Later (younger) matches overwrite earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) &&
                (ent_addr[PTR_W'(head + PTR_W'(i))] == lookup_addr)) begin
                hit  = 1'b1;
                data = ent_data[PTR_W'(head + PTR_W'(i))];
            end
        end
    end

endmodule

// File: rtl/write_buffer.sv
// Write-through buffer between the L1 cache and main memory.
// Optional store forwarding is enabled by defining WB_FORWARD_EN.
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     write_en,
    input  logic [ADDR_W-1:0]        write_addr,
    input  logic [DATA_W-1:0]        write_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_data,
    input  logic                     mem_ack,
    input  logic [ADDR_W-1:0]        lookup_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    wb_state_t         state;
    wb_state_t         state_nxt;
    logic              push;
    logic              pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign push  = write_en && !full;
    assign pop   = (state == REQ) && mem_ack;

    // Entry storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= write_addr;
            ent_data[tail] <= write_data;
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
            if (write_en && full)
                overflow <= 1'b1;
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Drain FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (!empty) state_nxt = REQ;
            REQ:  if (mem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Drain FSM outputs.
    always_comb begin
        mem_req = (state == REQ);
    end

    // Capture the head entry on entering REQ; held frozen until acked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr <= '0;
            mem_data <= '0;
        end else if (state == IDLE && !empty) begin
            mem_addr <= ent_addr[head];
            mem_data <= ent_data[head];
        end
    end

`ifdef WB_FORWARD_EN
    wb_forward_match #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .CNT_W  (CNT_W)
    ) u_fwd (
        .ent_addr    (ent_addr),
        .ent_data    (ent_data),
        .head        (head),
        .count       (count),
        .lookup_addr (lookup_addr),
        .hit         (fwd_hit),
        .data        (fwd_data)
    );
`else
    logic unused_lookup;
    assign unused_lookup = ^lookup_addr;
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_write_buffer.sv
// Directed self-checking bench for write_buffer.
// Covers reset, drain handshake, overflow, wrap, forwarding, async reset.
module tb_write_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_en;
    logic [16:0] write_addr;
    logic [31:0] write_data;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        overflow;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ack;
    logic [16:0] lookup_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    int nvec = 0;
    int nerr = 0;

    logic [16:0] exp_addr [8];
    logic [31:0] exp_data [8];

    write_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_ack     (mem_ack),
        .lookup_addr (lookup_addr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [16:0] a, input logic [31:0] d);
        write_en   = 1'b1;
        write_addr = a;
        write_data = d;
        step();
        write_en   = 1'b0;
    endtask

    // Hold ack high and check entries come out in order, 2 cycles apart.
    task automatic drain(input int n);
        int k;
        int last;
        k = 0;
        last = 0;
        mem_ack = 1'b1;
        for (int cyc = 0; cyc < 4 * n + 4; cyc++) begin
            if (mem_req) begin
                if (k < n) begin
                    chk("drain_addr", 64'(mem_addr), 64'(exp_addr[k]));
                    chk("drain_data", 64'(mem_data), 64'(exp_data[k]));
                end
                if (k > 0) chk("drain_gap", 64'(cyc - last), 64'd2);
                last = cyc;
                k++;
            end
            if (!mem_req && empty) break;
            step();
        end
        chk("drain_n", 64'(k), 64'(n));
        chk("drain_empty", 64'(empty), 64'd1);
        mem_ack = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        write_en    = 1'b0;
        write_addr  = '0;
        write_data  = '0;
        mem_ack     = 1'b0;
        lookup_addr = '0;
        #12;
        chk("rst_full",     64'(full),     64'd0);
        chk("rst_empty",    64'(empty),    64'd1);
        chk("rst_count",    64'(count),    64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_mem_req",  64'(mem_req),  64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_data", 64'(mem_data), 64'd0);
        chk("rst_fwd_hit",  64'(fwd_hit),  64'd0);
        chk("rst_fwd_data", 64'(fwd_data), 64'd0);
        rst = 1'b0;

        // single store, request after two edges, ack delayed 3 cycles
        store(17'h00003, 32'h0000003F);
        chk("s1_empty", 64'(empty),   64'd0);
        chk("s1_count", 64'(count),   64'd1);
        chk("s1_req0",  64'(mem_req), 64'd0);
        step();
        chk("s1_req1", 64'(mem_req),  64'd1);
        chk("s1_addr", 64'(mem_addr), 64'h3);
        chk("s1_data", 64'(mem_data), 64'h3F);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s1_hold_req",  64'(mem_req),  64'd1);
            chk("s1_hold_addr", 64'(mem_addr), 64'h3);
            chk("s1_hold_data", 64'(mem_data), 64'h3F);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("s1_req_drop", 64'(mem_req), 64'd0);
        chk("s1_empty2",   64'(empty),   64'd1);

        // fill to full, then overflow; head starts at 1 so drain wraps
        exp_addr[0] = 17'h00003; exp_data[0] = 32'h000000A0;
        exp_addr[1] = 17'h00033; exp_data[1] = 32'h000000A1;
        exp_addr[2] = 17'h1C033; exp_data[2] = 32'h000000A2;
        exp_addr[3] = 17'h00001; exp_data[3] = 32'h000000A3;
        for (int i = 0; i < 4; i++) store(exp_addr[i], exp_data[i]);
        chk("f_full",  64'(full),  64'd1);
        chk("f_count", 64'(count), 64'd4);
        chk("f_ovf0",  64'(overflow), 64'd0);
        store(17'h00005, 32'h000000FF);
        chk("f_ovf1",   64'(overflow), 64'd1);
        chk("f_count2", 64'(count),    64'd4);
        drain(4);
        chk("f_ovf_sticky", 64'(overflow), 64'd1);

        // store and ack on the same edge with two entries held
        store(17'h00011, 32'h00000001);
        store(17'h00022, 32'h00000002);
        chk("sa_count", 64'(count),    64'd2);
        chk("sa_addr",  64'(mem_addr), 64'h11);
        write_en   = 1'b1;
        write_addr = 17'h00044;
        write_data = 32'h00000004;
        mem_ack    = 1'b1;
        step();
        write_en = 1'b0;
        chk("sa_count2", 64'(count), 64'd2);
        exp_addr[0] = 17'h00022; exp_data[0] = 32'h00000002;
        exp_addr[1] = 17'h00044; exp_data[1] = 32'h00000004;
        drain(2);

        // forwarding: youngest of two same-address stores wins
        store(17'h00033, 32'h00003C3C);
        store(17'h00033, 32'h01FE3C3C);
        store(17'h00007, 32'h00000077);
        lookup_addr = 17'h00033;
        #1;
`ifdef WB_FORWARD_EN
        chk("fw_hit",  64'(fwd_hit),  64'd1);
        chk("fw_data", 64'(fwd_data), 64'h01FE3C3C);
        lookup_addr = 17'h00007;
        #1;
        chk("fw_hit7",  64'(fwd_hit),  64'd1);
        chk("fw_data7", 64'(fwd_data), 64'h77);
`else
        chk("fw_off_hit",  64'(fwd_hit),  64'd0);
        chk("fw_off_data", 64'(fwd_data), 64'd0);
`endif
        lookup_addr = 17'h00005;
        #1;
        chk("fw_miss_hit",  64'(fwd_hit),  64'd0);
        chk("fw_miss_data", 64'(fwd_data), 64'd0);

        // asynchronous reset mid-request with three entries
        chk("ar_pre_count", 64'(count),    64'd3);
        chk("ar_pre_req",   64'(mem_req),  64'd1);
        chk("ar_pre_ovf",   64'(overflow), 64'd1);
        rst = 1'b1;
        #1;
        chk("ar_req",   64'(mem_req),  64'd0);
        chk("ar_empty", 64'(empty),    64'd1);
        chk("ar_ovf",   64'(overflow), 64'd0);
        chk("ar_count", 64'(count),    64'd0);
        lookup_addr = 17'h00033;
        #1;
        chk("ar_fwd_hit", 64'(fwd_hit), 64'd0);
        rst = 1'b0;
        step();
        step();
        chk("ar_post_req",   64'(mem_req), 64'd0);
        chk("ar_post_empty", 64'(empty),   64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
